// File: rtl/crp_pkg.sv
// Shared types, ASCII constants and helpers for the CRP batch collector.
// CRP_STABILITY_FLAG_EN adds the ",S"/",U" stability field to each line.
package crp_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAdvance,
    StLaunch,
    StSettle,
    StSample,
    StVote,
    StPrint,
    StPwait,
    StNext
  } crp_state_e;

  localparam logic [7:0] AsciiC     = 8'h43;
  localparam logic [7:0] AsciiComma = 8'h2C;
  localparam logic [7:0] AsciiR     = 8'h52;
  localparam logic [7:0] AsciiNl    = 8'h0A;
  localparam logic [7:0] AsciiS     = 8'h53;
  localparam logic [7:0] AsciiU     = 8'h55;
  localparam logic [7:0] AsciiZero  = 8'h30;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return AsciiZero + {4'd0, nib};
    return 8'h41 + {4'd0, nib} - 8'd10;
  endfunction

  // "C," + hex + ",R," + bit + "," + two hex + "\n", plus ",S"/",U" when enabled.
  function automatic int unsigned line_len(input int unsigned n);
`ifdef CRP_STABILITY_FLAG_EN
    return n / 4 + 12;
`else
    return n / 4 + 10;
`endif
  endfunction

endpackage

// File: rtl/crp_line_serializer.sv
// Combinational byte-index to ASCII mux for one CSV line of a CRP.
// CRP_STABILITY_FLAG_EN inserts the stability field before the newline.
module crp_line_serializer
  import crp_pkg::*;
#(
  parameter int unsigned N = 64
`ifdef CRP_STABILITY_FLAG_EN
  , parameter int unsigned K = 5
`endif
) (
  input  logic [7:0]   byte_idx,
  input  logic [N-1:0] chal,
  input  logic         voted,
  input  logic [7:0]   ones_cnt,
  output logic [7:0]   data,
  output logic         last_byte
);

  localparam int unsigned HexLen  = N / 4;
  localparam int unsigned LineLen = line_len(N);

  int unsigned idx;

  always_comb begin
    idx  = 32'(byte_idx);
    data = AsciiNl;
    if (idx == 0) begin
      data = AsciiC;
    end else if (idx == 1) begin
      data = AsciiComma;
    end else if (idx <= HexLen + 1) begin
      // Most significant nibble first.
      data = hex_ascii(chal[4*(HexLen+1-idx) +: 4]);
    end else if (idx == HexLen + 2) begin
      data = AsciiComma;
    end else if (idx == HexLen + 3) begin
      data = AsciiR;
    end else if (idx == HexLen + 4) begin
      data = AsciiComma;
    end else if (idx == HexLen + 5) begin
      data = AsciiZero + {7'd0, voted};
    end else if (idx == HexLen + 6) begin
      data = AsciiComma;
    end else if (idx == HexLen + 7) begin
      data = hex_ascii(ones_cnt[7:4]);
    end else if (idx == HexLen + 8) begin
      data = hex_ascii(ones_cnt[3:0]);
`ifdef CRP_STABILITY_FLAG_EN
    end else if (idx == HexLen + 9) begin
      data = AsciiComma;
    end else if (idx == HexLen + 10) begin
      data = (ones_cnt == 8'd0 || ones_cnt == 8'(K)) ? AsciiS : AsciiU;
`endif
    end
    last_byte = (idx == LineLen - 1);
  end

endmodule

// File: rtl/crp_batch_collector.sv
// Collects batches of majority-voted arbiter PUF CRPs and streams them as CSV lines.
// CRP_STABILITY_FLAG_EN adds the stability field and the unstable output.
module crp_batch_collector
  import crp_pkg::*;
#(
  parameter int unsigned N          = 64,
  parameter int unsigned K          = 5,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned BATCH      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] chal_in,
  output logic         chal_adv,
  output logic         puf_launch,
  input  logic         puf_resp,
  output logic         uart_start,
  output logic [7:0]   uart_data,
  input  logic         uart_busy,
  output logic         voted_bit,
  output logic         busy,
  output logic [15:0]  crp_count
`ifdef CRP_STABILITY_FLAG_EN
  , output logic       unstable
`endif
);

  localparam int unsigned SW         = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);
  localparam logic [7:0]  KLast      = 8'(K - 1);
  localparam logic [7:0]  Half       = 8'((K + 1) / 2);
  localparam bit          BatchEn    = (BATCH != 0);
  localparam logic [16:0] BatchLen   = 17'(BATCH);

  crp_state_e    state_q, state_d;
  logic [N-1:0]  chal_q, chal_d;
  logic [7:0]    ones_q, ones_d, k_q, k_d, idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          pw_first_q, pw_first_d;
  logic          stop_seen_q, stop_seen_d;
  logic          voted_q, voted_d;
  logic [15:0]   count_q, count_d;
  logic [7:0]    ser_data;
  logic          last_byte;
`ifdef CRP_STABILITY_FLAG_EN
  logic          unstable_q, unstable_d;
`endif

  crp_line_serializer #(
    .N(N)
`ifdef CRP_STABILITY_FLAG_EN
    , .K(K)
`endif
  ) u_ser (
    .byte_idx (idx_q),
    .chal     (chal_q),
    .voted    (voted_q),
    .ones_cnt (ones_q),
    .data     (ser_data),
    .last_byte(last_byte)
  );

  always_comb begin
    state_d     = state_q;
    chal_d      = chal_q;
    ones_d      = ones_q;
    k_d         = k_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    pw_first_d  = 1'b0;
    stop_seen_d = stop_seen_q | stop;
    voted_d     = voted_q;
    count_d     = count_q;
    chal_adv    = 1'b0;
    puf_launch  = 1'b0;
    uart_start  = 1'b0;
`ifdef CRP_STABILITY_FLAG_EN
    unstable_d  = unstable_q;
`endif
    unique case (state_q)
      StIdle: begin
        stop_seen_d = 1'b0;
        if (start) begin
          count_d     = '0;
          ones_d      = '0;
          k_d         = '0;
          stop_seen_d = stop;
          state_d     = StAdvance;
        end
      end
      StAdvance: begin
        chal_adv = 1'b1;
        state_d  = StLaunch;
      end
      StLaunch: begin
        puf_launch = 1'b1;
        // The generator has moved on by now; hold this value for all K launches.
        if (k_q == 8'd0) chal_d = chal_in;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleLast) state_d = StSample;
        else settle_d = settle_q + 1'b1;
      end
      StSample: begin
        ones_d  = ones_q + {7'd0, puf_resp};
        k_d     = k_q + 8'd1;
        state_d = (k_q == KLast) ? StVote : StLaunch;
      end
      StVote: begin
        voted_d = (ones_q >= Half);
`ifdef CRP_STABILITY_FLAG_EN
        unstable_d = !(ones_q == 8'd0 || ones_q == 8'(K));
`endif
        idx_d   = '0;
        state_d = StPrint;
      end
      StPrint: begin
        if (!uart_busy) begin
          uart_start = 1'b1;
          pw_first_d = 1'b1;
          state_d    = StPwait;
        end
      end
      StPwait: begin
        // uart_tx only raises busy the cycle after start, so skip the first cycle.
        if (!pw_first_q && !uart_busy) begin
          if (last_byte) begin
            state_d = StNext;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StPrint;
          end
        end
      end
      StNext: begin
        ones_d = '0;
        k_d    = '0;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (stop_seen_q || stop || (BatchEn && ({1'b0, count_q} + 17'd1 >= BatchLen))) begin
          stop_seen_d = 1'b0;
          state_d     = StIdle;
        end else begin
          state_d = StAdvance;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      chal_q      <= '0;
      ones_q      <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      settle_q    <= '0;
      pw_first_q  <= 1'b0;
      stop_seen_q <= 1'b0;
      voted_q     <= 1'b0;
      count_q     <= '0;
`ifdef CRP_STABILITY_FLAG_EN
      unstable_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      chal_q      <= chal_d;
      ones_q      <= ones_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      pw_first_q  <= pw_first_d;
      stop_seen_q <= stop_seen_d;
      voted_q     <= voted_d;
      count_q     <= count_d;
`ifdef CRP_STABILITY_FLAG_EN
      unstable_q  <= unstable_d;
`endif
    end
  end

  assign uart_data = uart_start ? ser_data : 8'd0;
  assign busy      = (state_q != StIdle);
  assign voted_bit = voted_q;
  assign crp_count = count_q;
`ifdef CRP_STABILITY_FLAG_EN
  assign unstable  = unstable_q;
`endif

endmodule

// File: tb/tb_crp_batch_collector.sv
// Scoreboard bench for crp_batch_collector (N=8, K=5, SETTLE_CYC=3, BATCH=3).
// Build with CRP_STABILITY_FLAG_EN to also check the stability field and port.
module tb_crp_batch_collector;

  localparam int unsigned N = 8;
  localparam int unsigned K = 5;
  localparam int unsigned S = 3;
  localparam int unsigned BATCH = 3;
`ifdef CRP_STABILITY_FLAG_EN
  localparam int LL = 14;
`else
  localparam int LL = 12;
`endif

  logic clk = 1'b0;
  logic rst, start, stop, puf_resp;
  logic [N-1:0] chal_in = '0;
  logic chal_adv, puf_launch, uart_start, uart_busy, voted_bit, busy;
  logic [7:0] uart_data;
  logic [15:0] crp_count;
`ifdef CRP_STABILITY_FLAG_EN
  logic unstable;
`endif

  always #5 clk = ~clk;

  crp_batch_collector #(
    .N(N), .K(K), .SETTLE_CYC(S), .BATCH(BATCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .chal_in   (chal_in),
    .chal_adv  (chal_adv),
    .puf_launch(puf_launch),
    .puf_resp  (puf_resp),
    .uart_start(uart_start),
    .uart_data (uart_data),
    .uart_busy (uart_busy),
    .voted_bit (voted_bit),
    .busy      (busy),
    .crp_count (crp_count)
`ifdef CRP_STABILITY_FLAG_EN
    , .unstable(unstable)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lfsr_idx = 0;
  int busy_cnt = 0;
  int ublen = 2;
  int adv_cnt = 0;
  int launch_cnt = 0;
  int run_bytes = 0;
  int launch_cyc = -100;
  int last_start = -10;
  logic cur_want = 1'b0;
  logic [7:0] exp_q[$];
  logic resp_q[$];
  logic [7:0] chal_tab [0:6] = '{8'hA5, 8'h3C, 8'hE1, 8'h5A, 8'h0F, 8'hC3, 8'h96};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Challenge generator and UART transmitter models.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chal_adv) begin
      chal_in  <= chal_tab[lfsr_idx % 7];
      lfsr_idx <= lfsr_idx + 1;
    end else if (puf_launch) begin
      chal_in <= ~chal_in;
    end
    if (uart_start) busy_cnt <= ublen;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0);

  // PUF model (correct bit only in the sample cycle) and byte monitor.
  always @(negedge clk) begin
    if (chal_adv) adv_cnt++;
    if (puf_launch) begin
      launch_cnt++;
      launch_cyc = cyc;
      if (resp_q.size() == 0) begin
        check("extra_launch", 1, 0);
        cur_want = 1'b0;
      end else begin
        cur_want = resp_q.pop_front();
      end
    end
    puf_resp = (cyc == launch_cyc + int'(S) + 1) ? cur_want : ~cur_want;
    if (uart_start) begin
      run_bytes++;
      check("start_gap_ok", 32'(cyc - last_start >= 2), 1);
      check("busy_at_start", uart_busy, 0);
      last_start = cyc;
      if (exp_q.size() == 0) check("unexpected_byte", uart_data, 32'hFFFF);
      else check("uart_byte", uart_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_line(input string body, input bit stable);
    push_str(body);
`ifdef CRP_STABILITY_FLAG_EN
    push_str(stable ? ",S" : ",U");
`endif
    push_str("\n");
  endtask

  task automatic push_resp(input string s);
    for (int i = 0; i < s.len(); i++) resp_q.push_back(s[i] == 8'h31);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_bytes(input string name, input int target, input int budget);
    int n = 0;
    while (run_bytes < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(run_bytes >= target), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_chal_adv"}, chal_adv, 0);
    check({tag, "_puf_launch"}, puf_launch, 0);
    check({tag, "_uart_start"}, uart_start, 0);
    check({tag, "_uart_data"}, uart_data, 0);
    check({tag, "_voted_bit"}, voted_bit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_crp_count"}, crp_count, 0);
`ifdef CRP_STABILITY_FLAG_EN
    check({tag, "_unstable"}, unstable, 0);
`endif
  endtask

  initial begin
    int adv0, l0, rb0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Batch of three; a second start mid-batch must be ignored.
    push_resp("10110");
    push_resp("00100");
    push_resp("11111");
    push_line("C,A5,R,1,03", 1'b0);
    push_line("C,3C,R,0,01", 1'b0);
    push_line("C,E1,R,1,05", 1'b1);
    adv0 = adv_cnt;
    l0 = launch_cnt;
    pulse_start();
    repeat (40) tick();
    pulse_start();
    wait_idle("batch_idle", 3000);
    check("batch_adv_pulses", adv_cnt - adv0, 3);
    check("batch_launches", launch_cnt - l0, 15);
    check("batch_crp_count", crp_count, 3);
    check("batch_voted", voted_bit, 1);
    check("batch_bytes_left", exp_q.size(), 0);
    check("batch_resp_left", resp_q.size(), 0);
`ifdef CRP_STABILITY_FLAG_EN
    check("batch_unstable", unstable, 0);
`endif

    // Stop during line 2: line 2 completes, no third line.
    push_resp("00000");
    push_resp("11011");
    push_line("C,5A,R,0,00", 1'b1);
    push_line("C,0F,R,1,04", 1'b0);
    adv0 = adv_cnt;
    l0 = launch_cnt;
    rb0 = run_bytes;
    pulse_start();
    wait_bytes("stop_point", rb0 + LL + 5, 3000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("stop_idle", 3000);
    check("stop_crp_count", crp_count, 2);
    check("stop_adv_pulses", adv_cnt - adv0, 2);
    check("stop_launches", launch_cnt - l0, 10);
    check("stop_voted", voted_bit, 1);
    check("stop_bytes_left", exp_q.size(), 0);
`ifdef CRP_STABILITY_FLAG_EN
    check("stop_unstable", unstable, 1);
`endif

    // Slow UART, then reset in the middle of line 2.
    ublen = 20;
    push_resp("10000");
    push_resp("11100");
    push_line("C,C3,R,0,01", 1'b0);
    push_line("C,96,R,1,03", 1'b0);
    rb0 = run_bytes;
    pulse_start();
    wait_bytes("slow_point", rb0 + LL + 6, 8000);
    check("slow_voted", voted_bit, 1);
    check("slow_crp_count", crp_count, 1);
    check("slow_busy", busy, 1);
    rst = 1'b1;
    tick();
    check_all_zero("midline_rst");
    exp_q.delete();
    rst = 1'b0;
    repeat (60) tick();
    check("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
